// File: rtl/regfile_2w4r.sv
// regfile_2w4r: 32 x 32-bit general-purpose register file for the dual-issue pipeline.
// Two write ports (WB slot 1 = older, slot 2 = younger) and four combinational read ports.
// Register $0 reads as zero. Optional same-cycle write-to-read bypass.
module regfile_2w4r #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NREG         = 32,
    parameter bit          WRITE_BYPASS = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wen1,
    input  logic [$clog2(NREG)-1:0] waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    wen2,
    input  logic [$clog2(NREG)-1:0] waddr2,
    input  logic [DATA_W-1:0]       wdata2,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    input  logic [$clog2(NREG)-1:0] raddr3,
    input  logic [$clog2(NREG)-1:0] raddr4,
    output logic [DATA_W-1:0]       rdata1,
    output logic [DATA_W-1:0]       rdata2,
    output logic [DATA_W-1:0]       rdata3,
    output logic [DATA_W-1:0]       rdata4
);

    localparam int unsigned AW     = $clog2(NREG);
    localparam int unsigned NRPORT = 4;

    logic [DATA_W-1:0] regs    [NREG];
    logic [AW-1:0]     raddr_a [NRPORT];
    logic [DATA_W-1:0] rdata_a [NRPORT];

    // Qualified write strobes: writes to $0 are discarded
    logic we1_c;
    logic we2_c;

    assign we1_c = wen1 && (waddr1 != '0);
    assign we2_c = wen2 && (waddr2 != '0);

    // Storage update; slot 2 is assigned last so the younger write wins an address conflict
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we1_c) begin
                regs[waddr1] <= wdata1;
            end
            if (we2_c) begin
                regs[waddr2] <= wdata2;
            end
        end
    end

    assign raddr_a[0] = raddr1;
    assign raddr_a[1] = raddr2;
    assign raddr_a[2] = raddr3;
    assign raddr_a[3] = raddr4;

    // Combinational read with optional bypass; forced to zero for $0 and while in reset
    always_comb begin
        for (int p = 0; p < int'(NRPORT); p++) begin
            rdata_a[p] = '0;
            if (resetn && (raddr_a[p] != '0)) begin
                rdata_a[p] = regs[raddr_a[p]];
                if (WRITE_BYPASS) begin
                    if (wen2 && (waddr2 == raddr_a[p])) begin
                        rdata_a[p] = wdata2;
                    end else if (wen1 && (waddr1 == raddr_a[p])) begin
                        rdata_a[p] = wdata1;
                    end
                end
            end
        end
    end

    assign rdata1 = rdata_a[0];
    assign rdata2 = rdata_a[1];
    assign rdata3 = rdata_a[2];
    assign rdata4 = rdata_a[3];

endmodule
